pinmux_func_switch_ctrl: RTL and testbench
==========================================

Name: pinmux_func_switch_ctrl

Overview:
Per-pin sequencer that reconfigures one pinmux cell's function select with break-before-make ordering.
- Accepts a function-change request and first drains the pad: output qualifier, input enable and input-function routing all go low.
- Waits a programmable settle time, switches select and open-drain mode, then re-enables input followed by output.
- A port-stop input forces the pad safe and restores it afterwards.
- Sits between the pin configuration register block and the pinmux datapath, driving its outfunc_sel, infunc_en, od, ie and gpioquten controls.

Parameters:
SEL_WIDTH, 5, width of function select.
NUM_FUNC, 32, number of valid functions; select values >= NUM_FUNC are illegal.
CNT_WIDTH, 4, width of settle counter.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset, asynchronous, active-low.
i_req  in  1  change request, level; must be held with payload stable until o_ack.
i_req_sel  in  SEL_WIDTH  requested function.
i_req_od  in  1  requested open-drain mode.
i_req_infunc  in  1  1 = route pad input to the selected function's infunc_en bit.
i_settle_cycles  in  CNT_WIDTH  drain/settle delay N, static while o_busy.
i_portstop  in  1  port-stop (error) force, level.
o_ack  out  1  one-cycle completion pulse.
o_err  out  1  valid with o_ack; 1 = request rejected (illegal select).
o_busy  out  1  sequence or port-stop in progress.
o_outfunc_sel  out  SEL_WIDTH  to pinmux outfunc select.
o_infunc_en  out  NUM_FUNC  one-hot input-function enable.
o_pinctlx_od  out  1  open-drain control.
o_pinctlx_ie  out  1  pad input enable.
o_gpioquten  out  1  output qualifier (final OE gate).

Behaviour:
Register and reset rules:
- All outputs are registered.
- Async reset (also mid-sequence) clears every output to 0 immediately. The FSM returns to IDLE and the counter clears to 0.

FSM states: IDLE, DRAIN, SWITCH, IE_ON, EN_ON, STOP.

Edge-by-edge sequence:
- IDLE, i_req=1, i_req_sel<NUM_FUNC, i_portstop=0: latch sel/od/infunc. Set o_gpioquten, o_pinctlx_ie and o_infunc_en to 0, cnt<=N, o_busy<=1, go to DRAIN.
- IDLE, i_req=1, i_req_sel>=NUM_FUNC: o_ack<=1 and o_err<=1 for one cycle. No configuration change; remain in IDLE.
- DRAIN: if cnt!=0, decrement; else go to SWITCH. N=0 gives one DRAIN cycle.
- SWITCH: o_outfunc_sel and o_pinctlx_od take the latched values; go to IE_ON.
- IE_ON: o_pinctlx_ie<=1; go to EN_ON.
- EN_ON: o_infunc_en<=onehot(sel) if latched infunc=1, else 0. o_gpioquten<=1, o_ack<=1 (err=0), o_busy<=0; go to IDLE.

Timing and handshake:
- o_ack is high in the cycle following edge k+N+3, where k is the accept edge.
- o_ack and o_err clear on the next edge.
- i_req is ignored while o_busy=1.
- After o_ack, the requester must drop i_req for at least one cycle; a held i_req in IDLE is a new request.
- The same select is not special-cased; the full sequence runs.
- Select and od never change while o_gpioquten=1 or o_pinctlx_ie=1 (break-before-make invariant).

Port-stop:
- i_portstop=1 in any state, with highest priority including over a simultaneous i_req: on the next edge set o_gpioquten, o_pinctlx_ie and o_infunc_en to 0, o_busy<=1, go to STOP.
- o_outfunc_sel and o_pinctlx_od are held.
- An in-flight request is aborted: o_ack<=1 and o_err<=1 on entry.
- STOP remains while i_portstop=1.
- On deassert: cnt<=N, set the restore flag, go to DRAIN, and replay SWITCH/IE_ON/EN_ON with the current configuration.
- A restore completes with no o_ack.
- i_portstop re-asserting during a restore returns to STOP with no ack.
- If the pad was never configured since reset, restore still runs and ends with o_gpioquten=1 on select 0, od 0, infunc 0.

Test Plan:
- Reset: i_rst_n=0 mid-DRAIN → all outputs 0 asynchronously; after release, o_busy=0 and FSM idle.
- Normal switch, N=4: req sel=3, od=0, infunc=1 accepted at edge k → quten/ie drop after k; sel=3 after k+5; ie=1 after k+6; infunc_en=32'h8, quten=1, ack=1 after k+7; ack=0 after k+8.
- N=0 with od=1, sel=31 → ack 3 edges after accept; o_pinctlx_od=1; o_outfunc_sel=31.
- Illegal sel with NUM_FUNC=20, req sel=25 → ack=1, err=1 one cycle later; outputs unchanged; busy stays 0.
- Port-stop during DRAIN → ack=1, err=1; quten/ie/infunc=0; sel unchanged. Deassert → restore of old sel with N+3 edge timing, no ack.
- Port-stop and i_req asserted on the same edge in IDLE → STOP entered, no ack, request ignored; invariant checker confirms no select change while quten or ie is 1 across random stimulus.

Source files
------------

// File: rtl/pinmux_func_switch_ctrl.sv
// Break-before-make function-select sequencer for a single pinmux cell.
// Drains the pad, waits a settle time, switches select/od, then re-enables input and output.
module pinmux_func_switch_ctrl #(
   parameter int SEL_WIDTH = 5,
   parameter int NUM_FUNC  = 32,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req,
   input  logic [SEL_WIDTH-1:0] i_req_sel,
   input  logic                 i_req_od,
   input  logic                 i_req_infunc,
   input  logic [CNT_WIDTH-1:0] i_settle_cycles,
   input  logic                 i_portstop,
   output logic                 o_ack,
   output logic                 o_err,
   output logic                 o_busy,
   output logic [SEL_WIDTH-1:0] o_outfunc_sel,
   output logic [NUM_FUNC-1:0]  o_infunc_en,
   output logic                 o_pinctlx_od,
   output logic                 o_pinctlx_ie,
   output logic                 o_gpioquten
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_SWITCH = 3'd2,
      ST_IE_ON  = 3'd3,
      ST_EN_ON  = 3'd4,
      ST_STOP   = 3'd5
   } state_e;

   localparam logic [31:0]          NUM_FUNC_U = 32'(NUM_FUNC);
   localparam logic [NUM_FUNC-1:0]  ONE_FUNC   = {{(NUM_FUNC-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e               state_q,      state_d;
   logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;
   logic                 restore_q,    restore_d;
   logic [SEL_WIDTH-1:0] lat_sel_q,    lat_sel_d;
   logic                 lat_od_q,     lat_od_d;
   logic                 lat_infunc_q, lat_infunc_d;
   logic                 cur_infunc_q, cur_infunc_d;
   logic                 ack_q,        ack_d;
   logic                 err_q,        err_d;
   logic                 busy_q,       busy_d;
   logic [SEL_WIDTH-1:0] sel_q,        sel_d;
   logic [NUM_FUNC-1:0]  infunc_en_q,  infunc_en_d;
   logic                 od_q,         od_d;
   logic                 ie_q,         ie_d;
   logic                 quten_q,      quten_d;

   logic req_legal;
   logic in_flight;

   assign req_legal = (32'(i_req_sel) < NUM_FUNC_U);
   // A user request still owes its requester an ack until EN_ON is reached.
   assign in_flight = !restore_q &&
                      ((state_q == ST_DRAIN) || (state_q == ST_SWITCH) || (state_q == ST_IE_ON));

   // Each state's pad update is registered on the edge that enters it, so the
   // ack lands in the cycle after edge k+N+3.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      cnt_d        = cnt_q;
      restore_d    = restore_q;
      lat_sel_d    = lat_sel_q;
      lat_od_d     = lat_od_q;
      lat_infunc_d = lat_infunc_q;
      cur_infunc_d = cur_infunc_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      busy_d       = busy_q;
      sel_d        = sel_q;
      infunc_en_d  = infunc_en_q;
      od_d         = od_q;
      ie_d         = ie_q;
      quten_d      = quten_q;

      if (i_portstop) begin
         if (in_flight) begin
            ack_d = 1'b1;
            err_d = 1'b1;
         end
         quten_d     = 1'b0;
         ie_d        = 1'b0;
         infunc_en_d = '0;
         busy_d      = 1'b1;
         restore_d   = 1'b0;
         state_d     = ST_STOP;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_req) begin
                  if (req_legal) begin
                     lat_sel_d    = i_req_sel;
                     lat_od_d     = i_req_od;
                     lat_infunc_d = i_req_infunc;
                     quten_d      = 1'b0;
                     ie_d         = 1'b0;
                     infunc_en_d  = '0;
                     cnt_d        = i_settle_cycles;
                     busy_d       = 1'b1;
                     restore_d    = 1'b0;
                     state_d      = ST_DRAIN;
                  end else begin
                     ack_d = 1'b1;
                     err_d = 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  sel_d        = lat_sel_q;
                  od_d         = lat_od_q;
                  cur_infunc_d = lat_infunc_q;
                  state_d      = ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               ie_d    = 1'b1;
               state_d = ST_IE_ON;
            end
            ST_IE_ON: begin
               infunc_en_d = lat_infunc_q ? (ONE_FUNC << lat_sel_q) : '0;
               quten_d     = 1'b1;
               ack_d       = !restore_q;
               busy_d      = 1'b0;
               state_d     = ST_EN_ON;
            end
            ST_EN_ON: begin
               restore_d = 1'b0;
               state_d   = ST_IDLE;
            end
            ST_STOP: begin
               // Replay the last committed configuration, not any aborted request.
               lat_sel_d    = sel_q;
               lat_od_d     = od_q;
               lat_infunc_d = cur_infunc_q;
               cnt_d        = i_settle_cycles;
               restore_d    = 1'b1;
               state_d      = ST_DRAIN;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         restore_q    <= 1'b0;
         lat_sel_q    <= '0;
         lat_od_q     <= 1'b0;
         lat_infunc_q <= 1'b0;
         cur_infunc_q <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         sel_q        <= '0;
         infunc_en_q  <= '0;
         od_q         <= 1'b0;
         ie_q         <= 1'b0;
         quten_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         restore_q    <= restore_d;
         lat_sel_q    <= lat_sel_d;
         lat_od_q     <= lat_od_d;
         lat_infunc_q <= lat_infunc_d;
         cur_infunc_q <= cur_infunc_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         sel_q        <= sel_d;
         infunc_en_q  <= infunc_en_d;
         od_q         <= od_d;
         ie_q         <= ie_d;
         quten_q      <= quten_d;
      end
   end

   assign o_ack         = ack_q;
   assign o_err         = err_q;
   assign o_busy        = busy_q;
   assign o_outfunc_sel = sel_q;
   assign o_infunc_en   = infunc_en_q;
   assign o_pinctlx_od  = od_q;
   assign o_pinctlx_ie  = ie_q;
   assign o_gpioquten   = quten_q;

endmodule

// File: tb/tb_pinmux_func_switch_ctrl.sv
// Bench for pinmux_func_switch_ctrl: directed timing scenarios plus random traffic
// compared against a timeline-based reference model.
module tb_pinmux_func_switch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       req20 = 1'b0;
   logic [4:0] sel = '0;
   logic       od = 1'b0;
   logic       infunc = 1'b0;
   logic [3:0] settle = '0;
   logic       portstop = 1'b0;

   logic        ack, err, busy, pod, pie, quten;
   logic [4:0]  osel;
   logic [31:0] inf;
   logic        ack20, err20, busy20, pod20, pie20, quten20;
   logic [4:0]  osel20;
   logic [19:0] inf20;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pinmux_func_switch_ctrl u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_sel(sel), .i_req_od(od),
      .i_req_infunc(infunc), .i_settle_cycles(settle), .i_portstop(portstop),
      .o_ack(ack), .o_err(err), .o_busy(busy), .o_outfunc_sel(osel), .o_infunc_en(inf),
      .o_pinctlx_od(pod), .o_pinctlx_ie(pie), .o_gpioquten(quten)
   );

   pinmux_func_switch_ctrl #(.NUM_FUNC(20)) u_dut20 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req20), .i_req_sel(sel), .i_req_od(od),
      .i_req_infunc(infunc), .i_settle_cycles(settle), .i_portstop(1'b0),
      .o_ack(ack20), .o_err(err20), .o_busy(busy20), .o_outfunc_sel(osel20), .o_infunc_en(inf20),
      .o_pinctlx_od(pod20), .o_pinctlx_ie(pie20), .o_gpioquten(quten20)
   );

   // Reference model: a per-sequence timeline counted in edges since the sequence start.
   logic        m_ack, m_err, m_busy, m_sel_od, m_ie, m_q, m_od;
   logic [4:0]  m_sel;
   logic [31:0] m_inf;
   logic        m_active, m_restore, m_stopped;
   int          m_t;
   logic [4:0]  m_tgt_sel, m_cm_sel;
   logic        m_tgt_od, m_tgt_inf, m_cm_od, m_cm_inf;

   task automatic model_reset();
      m_ack = 0; m_err = 0; m_busy = 0; m_ie = 0; m_q = 0; m_od = 0; m_sel = '0; m_inf = '0;
      m_active = 0; m_restore = 0; m_stopped = 0; m_t = 0;
      m_tgt_sel = '0; m_tgt_od = 0; m_tgt_inf = 0; m_cm_sel = '0; m_cm_od = 0; m_cm_inf = 0;
   endtask

   task automatic model_step();
      int n;
      n = int'(settle);
      m_ack = 0;
      m_err = 0;
      if (portstop) begin
         if (m_active && !m_restore && m_t <= n + 2) begin
            m_ack = 1;
            m_err = 1;
         end
         m_q = 0; m_ie = 0; m_inf = '0; m_busy = 1;
         m_active = 0; m_restore = 0; m_stopped = 1;
      end else if (m_stopped) begin
         m_stopped = 0; m_active = 1; m_restore = 1; m_t = 0;
         m_tgt_sel = m_cm_sel; m_tgt_od = m_cm_od; m_tgt_inf = m_cm_inf;
      end else if (m_active) begin
         m_t++;
         if (m_t == n + 1) begin
            m_sel = m_tgt_sel; m_od = m_tgt_od;
            m_cm_sel = m_tgt_sel; m_cm_od = m_tgt_od; m_cm_inf = m_tgt_inf;
         end else if (m_t == n + 2) begin
            m_ie = 1;
         end else if (m_t == n + 3) begin
            m_q = 1;
            m_inf = m_tgt_inf ? (32'h1 << m_tgt_sel) : 32'h0;
            m_ack = !m_restore;
            m_busy = 0;
         end else if (m_t >= n + 4) begin
            m_active = 0;
            m_restore = 0;
         end
      end else if (req) begin
         m_active = 1; m_restore = 0; m_t = 0; m_busy = 1;
         m_q = 0; m_ie = 0; m_inf = '0;
         m_tgt_sel = sel; m_tgt_od = od; m_tgt_inf = infunc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; req = 0; req20 = 0; portstop = 0;
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({ack, err, busy, osel, inf, pod, pie, quten} !== 43'h0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 0", {ack, err, busy, osel, inf, pod, pie, quten});
      end
   endtask

   task automatic test_normal();
      settle = 4; sel = 5'd3; od = 0; infunc = 1; req = 1;
      tick();
      n_checks++;
      if ({quten, pie, busy} !== 3'b001) begin
         n_err++; $display("FAIL normal_accept: got %b want 001", {quten, pie, busy});
      end
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j == 4) begin
            n_checks++;
            if (osel !== 5'd0) begin n_err++; $display("FAIL normal_sel_early: got %0d want 0", osel); end
         end
         if (j == 5) begin
            n_checks++;
            if ({osel, pod, pie} !== {5'd3, 1'b0, 1'b0}) begin
               n_err++; $display("FAIL normal_switch: got sel=%0d od=%b ie=%b want 3 0 0", osel, pod, pie);
            end
         end
         if (j == 6) begin
            n_checks++;
            if ({pie, quten, ack} !== 3'b100) begin
               n_err++; $display("FAIL normal_ie_on: got %b want 100", {pie, quten, ack});
            end
         end
         if (j == 7) begin
            n_checks++;
            if ({inf, quten, ack, err, busy} !== {32'h8, 4'b1100}) begin
               n_err++; $display("FAIL normal_en_on: got inf=%h q/a/e/b=%b want 8 1100", inf, {quten, ack, err, busy});
            end
            req = 0;
         end
         if (j == 8) begin
            n_checks++;
            if ({ack, busy} !== 2'b00) begin n_err++; $display("FAIL normal_ack_clear: got %b want 00", {ack, busy}); end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      settle = 8; sel = 5'd9; od = 1; infunc = 0; req = 1;
      repeat (3) tick();
      n_checks++;
      if ({busy, osel} !== {1'b1, 5'd3}) begin
         n_err++; $display("FAIL mid_drain_pre: got busy=%b sel=%0d want 1 3", busy, osel);
      end
      #2 rst_n = 0;
      #1;
      n_checks++;
      if ({ack, err, busy, osel, inf, pod, pie, quten} !== 43'h0) begin
         n_err++; $display("FAIL async_reset: got %h want 0", {ack, err, busy, osel, inf, pod, pie, quten});
      end
      req = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (2) tick();
      n_checks++;
      if ({busy, quten, ack} !== 3'b000) begin
         n_err++; $display("FAIL post_reset_idle: got %b want 000", {busy, quten, ack});
      end
   endtask

   task automatic test_n0_od();
      settle = 0; sel = 5'd31; od = 1; infunc = 0; req = 1;
      tick();
      for (int j = 1; j <= 4; j++) begin
         tick();
         if (j < 3) begin
            n_checks++;
            if (ack !== 1'b0) begin n_err++; $display("FAIL n0_early_ack: edge %0d got %b want 0", j, ack); end
         end
         if (j == 3) begin
            n_checks++;
            if ({ack, err, osel, pod, pie, quten, busy, inf} !== {2'b10, 5'd31, 4'b1110, 32'h0}) begin
               n_err++; $display("FAIL n0_done: got a/e=%b sel=%0d od/ie/q/b=%b inf=%h want 10 31 1110 0",
                                 {ack, err}, osel, {pod, pie, quten, busy}, inf);
            end
            req = 0;
         end
         if (j == 4) begin
            n_checks++;
            if ({ack, busy} !== 2'b00) begin n_err++; $display("FAIL n0_ack_clear: got %b want 00", {ack, busy}); end
         end
      end
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3] = '{5'd20, 5'd25, 5'd31};
      foreach (bad[i]) begin
         sel = bad[i]; req20 = 1;
         tick();
         n_checks++;
         if ({ack20, err20, busy20, osel20, quten20, pie20} !== {3'b110, 5'd0, 2'b00}) begin
            n_err++; $display("FAIL illegal_%0d: got a/e/b=%b sel=%0d q/ie=%b want 110 0 00",
                              bad[i], {ack20, err20, busy20}, osel20, {quten20, pie20});
         end
         req20 = 0;
         tick();
         n_checks++;
         if ({ack20, err20} !== 2'b00) begin n_err++; $display("FAIL illegal_clear_%0d: got %b want 00", bad[i], {ack20, err20}); end
      end
      settle = 0; sel = 5'd19; od = 0; infunc = 1; req20 = 1;
      tick();
      n_checks++;
      if ({busy20, ack20} !== 2'b10) begin n_err++; $display("FAIL legal19_accept: got %b want 10", {busy20, ack20}); end
      repeat (3) tick();
      n_checks++;
      if ({ack20, err20, inf20, osel20} !== {2'b10, 20'h80000, 5'd19}) begin
         n_err++; $display("FAIL legal19_done: got a/e=%b inf=%h sel=%0d want 10 80000 19", {ack20, err20}, inf20, osel20);
      end
      req20 = 0;
      tick();
   endtask

   task automatic test_portstop_drain();
      bit got_ack = 0;
      settle = 3; sel = 5'd5; od = 0; infunc = 1; req = 1;
      repeat (3) tick();
      n_checks++;
      if ({busy, osel} !== {1'b1, 5'd31}) begin n_err++; $display("FAIL ps_pre: got busy=%b sel=%0d want 1 31", busy, osel); end
      portstop = 1;
      tick();
      n_checks++;
      if ({ack, err, quten, pie, inf, osel, pod, busy} !== {4'b1100, 32'h0, 5'd31, 2'b11}) begin
         n_err++; $display("FAIL ps_abort: got a/e/q/ie=%b inf=%h sel=%0d od/b=%b want 1100 0 31 11",
                           {ack, err, quten, pie}, inf, osel, {pod, busy});
      end
      req = 0;
      repeat (3) begin
         tick();
         n_checks++;
         if ({ack, busy} !== 2'b01) begin n_err++; $display("FAIL ps_hold: got %b want 01", {ack, busy}); end
      end
      portstop = 0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (ack) got_ack = 1;
         if (j == 5) begin
            n_checks++;
            if ({osel, pod, pie} !== {5'd31, 2'b10}) begin
               n_err++; $display("FAIL ps_restore_switch: got sel=%0d od/ie=%b want 31 10", osel, {pod, pie});
            end
         end
         if (j == 6) begin
            n_checks++;
            if ({pie, quten} !== 2'b10) begin n_err++; $display("FAIL ps_restore_ie: got %b want 10", {pie, quten}); end
         end
         if (j == 7) begin
            n_checks++;
            if ({quten, pie, busy, inf} !== {3'b110, 32'h0}) begin
               n_err++; $display("FAIL ps_restore_done: got q/ie/b=%b inf=%h want 110 0", {quten, pie, busy}, inf);
            end
         end
      end
      n_checks++;
      if (got_ack !== 1'b0) begin n_err++; $display("FAIL ps_restore_noack: got %b want 0", got_ack); end
   endtask

   task automatic test_portstop_with_req();
      bit got_ack = 0;
      settle = 2; sel = 5'd7; od = 0; infunc = 0; req = 1; portstop = 1;
      tick();
      n_checks++;
      if ({ack, err, busy, quten, osel} !== {4'b0010, 5'd31}) begin
         n_err++; $display("FAIL ps_req_same: got a/e/b/q=%b sel=%0d want 0010 31", {ack, err, busy, quten}, osel);
      end
      req = 0; portstop = 0;
      for (int j = 1; j <= 6; j++) begin
         tick();
         if (ack) got_ack = 1;
      end
      n_checks++;
      if ({got_ack, quten, busy, osel} !== {3'b010, 5'd31}) begin
         n_err++; $display("FAIL ps_req_restore: got ack/q/b=%b sel=%0d want 010 31", {got_ack, quten, busy}, osel);
      end
   endtask

   task automatic test_random();
      int         ps_left = 0;
      logic [4:0] prev_sel;
      logic       prev_od, prev_gate;
      do_reset();
      model_reset();
      settle = 2;
      prev_sel = osel; prev_od = pod; prev_gate = quten | pie;
      for (int c = 0; c < 3000; c++) begin
         if (req && m_ack) begin
            req = 0;
         end else if (!req && $urandom_range(0, 3) == 0) begin
            sel = 5'($urandom_range(0, 31)); od = 1'($urandom); infunc = 1'($urandom); req = 1;
         end
         if (ps_left > 0) begin
            ps_left--;
            if (ps_left == 0) portstop = 0;
         end else if ($urandom_range(0, 39) == 0) begin
            portstop = 1;
            ps_left = $urandom_range(1, 6);
         end
         if (!m_busy && !m_active && !m_stopped && !portstop && $urandom_range(0, 49) == 0)
            settle = 4'($urandom_range(0, 5));
         @(posedge clk);
         model_step();
         @(negedge clk);
         n_checks++;
         if ({ack, err, busy, osel, inf, pod, pie, quten} !== {m_ack, m_err, m_busy, m_sel, m_inf, m_od, m_ie, m_q}) begin
            n_err++;
            $display("FAIL rand_cycle_%0d: got a/e/b=%b sel=%0d inf=%h od/ie/q=%b want %b %0d %h %b", c,
                     {ack, err, busy}, osel, inf, {pod, pie, quten},
                     {m_ack, m_err, m_busy}, m_sel, m_inf, {m_od, m_ie, m_q});
         end
         n_checks++;
         if (prev_gate && (osel !== prev_sel || pod !== prev_od)) begin
            n_err++;
            $display("FAIL rand_bbm_%0d: sel %0d->%0d od %b->%b while pad enabled", c, prev_sel, osel, prev_od, pod);
         end
         prev_sel = osel; prev_od = pod; prev_gate = quten | pie;
      end
      req = 0; portstop = 0;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_reset_mid_drain();
      test_n0_od();
      test_illegal();
      test_portstop_drain();
      test_portstop_with_req();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
